sha256_message_scheduler: RTL
=============================

Name: sha256_message_scheduler

Overview:
- Produces the 64-word SHA-256 message schedule W0..W63 for one 512-bit block, one word per accepted cycle.
- Sits in front of the Generator round engine and drives that engine's round-counter and wordIn inputs.
- Accepts a full padded block through a valid/ready handshake.
- Streams words out through a second valid/ready handshake so the round engine can stall it.

Parameters:
- NUM_ROUNDS, 64, number of words emitted per block. Legal range 17..64. 64 for SHA-256; smaller values are for short simulations only.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- blk_valid  in  1  blk_data holds a padded block
- blk_ready  out  1  scheduler can accept a block
- blk_data  in  512  block, big-endian words; M0 = bits 511:480, M15 = bits 31:0
- w_valid  out  1  w_word/w_round valid
- w_ready  in  1  consumer accepts current word
- w_word  out  32  schedule word W_t
- w_round  out  6  round index t
- w_last  out  1  high with the final word (t = NUM_ROUNDS-1)
- busy  out  1  block in progress (state RUN)

Behaviour:
- Reset (rst high at posedge):
  - state to IDLE; window registers, w_word, w_round and round counter to 0.
  - w_valid=0, w_last=0, busy=0.
  - blk_ready is 0 in any cycle where rst is high, otherwise equal to (state==IDLE).
- Storage: a 16 x 32-bit shift window win[0..15]. win[0] is the current word W_t; win[15] is W_{t+15}.
- New-word function, all adds mod 2^32 with carries above bit 31 discarded:
  - new = s1(win[14]) + win[9] + s0(win[1]) + win[0], which is W_{t+16}.
  - s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- IDLE:
  - blk_ready=1, w_valid=0.
  - On blk_valid&&blk_ready: load win[i]=M_i, round=0, go to RUN.
- RUN:
  - w_valid=1, w_word=win[0], w_round=round, w_last=(round==NUM_ROUNDS-1).
  - On w_valid&&w_ready with round<NUM_ROUNDS-1: win shifts down one (win[i]=win[i+1]), win[15]=new, round+=1.
  - On w_valid&&w_ready with round==NUM_ROUNDS-1: go to IDLE; w_valid and w_last drop next cycle.
- Outputs are registered/state-derived only. No combinational path from w_ready or blk_valid to any output.
- Latency:
  - Block accepted at edge N: W0 valid in the cycle after N.
  - With w_ready held high, W_t is presented in cycle N+1+t.
  - Last word accepted at edge L: blk_ready=1 in the cycle after L.
  - Minimum block-to-block period is NUM_ROUNDS+1 cycles.
- Stall: while w_valid&&!w_ready, w_word, w_round, w_last and win are held stable indefinitely.
- blk_valid during RUN is ignored (blk_ready=0). The upstream source must hold blk_data until accepted.
- Reset mid-block: aborts immediately, partial schedule discarded. w_valid=0 in the cycle after the reset edge. No further words are emitted for that block.
- Round counter never wraps past NUM_ROUNDS-1.

Test Plan:
- Reset check: hold rst high 3 cycles with blk_valid=1 -> blk_ready=0 and w_valid=0 throughout; first cycle after release shows blk_ready=1, busy=0, w_word=0.
- "abc" block, w_ready tied high:
  - Stimulus: blk_data = 0x61626380, then 14 zero words, then 0x00000018.
  - Expected: W0=0x61626380, W1..W14=0, W15=0x00000018, W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6.
  - w_round counts 0..63 on consecutive cycles; w_last only at round 63; all 64 words match the software model.
- All-zero block -> 64 words of 0x00000000; then blk_ready=1 exactly one cycle after the round-63 handshake.
- Backpressure on the "abc" block:
  - Stimulus: w_ready driven by a random pattern, including a 10-cycle low at round 16.
  - Expected: W16 held at 0x61626380 with w_round=16 for the whole stall.
  - Word sequence identical to the unstalled run; no word duplicated or dropped.
- Back-to-back blocks: blk_valid held high with two different random blocks -> second block accepted in the cycle blk_ready returns; both 64-word streams match the model and w_round restarts at 0.
- Reset mid-block: rst pulsed for one cycle at round 30 -> w_valid=0 in the next cycle; a subsequently loaded "abc" block produces the correct W0..W63 from round 0.

Source files
------------

// File: rtl/sha256_message_scheduler.sv
// SHA-256 message schedule generator.
// Accepts one padded 512-bit block and streams W0..W(NUM_ROUNDS-1), one word per
// accepted handshake, so the round engine can stall the stream at any point.
module sha256_message_scheduler #(
  parameter int unsigned NUM_ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_word,
  output logic [5:0]   w_round,
  output logic         w_last,
  output logic         busy
);

  localparam logic [5:0] LastRound = 6'(NUM_ROUNDS - 1);

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [5:0]  round_q, round_d;
  logic [31:0] new_word;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // W(t+16) from the current window; adds wrap mod 2^32.
  always_comb begin
    new_word = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
  end

  // Next-state logic: block load in IDLE, window shift on each accepted word in RUN.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    for (int i = 0; i < 16; i++) begin
      win_d[i] = win_q[i];
    end

    unique case (state_q)
      StIdle: begin
        if (blk_valid) begin
          for (int i = 0; i < 16; i++) begin
            win_d[i] = blk_data[511 - 32 * i -: 32];
          end
          round_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (w_ready) begin
          if (round_q == LastRound) begin
            // Counter stays at the last round; the next load clears it.
            state_d = StIdle;
          end else begin
            for (int i = 0; i < 15; i++) begin
              win_d[i] = win_q[i + 1];
            end
            win_d[15] = new_word;
            round_d   = round_q + 6'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, window and round registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      round_q <= '0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  // Outputs come from registers only; blk_ready is also masked while rst is asserted.
  always_comb begin
    blk_ready = !rst && (state_q == StIdle);
    w_valid   = (state_q == StRun);
    busy      = (state_q == StRun);
    w_word    = win_q[0];
    w_round   = round_q;
    w_last    = (state_q == StRun) && (round_q == LastRound);
  end

endmodule
